sha256_compress: RTL and testbench
==================================

# sha256_compress

Downstream consumer of the message-schedule stage in the SHA-256 datapath. Takes the 256-bit chaining value and the 64 schedule words W[0..63], streamed one per cycle. Runs the 64 compression rounds, one round per accepted word, then performs the final feed-forward addition. Presents the 256-bit intermediate or final digest with a one-cycle valid pulse.

## Interface
- No parameters. Round count is fixed at 64; word width is fixed at 32.
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; clock `clock`
- `start`  in  1  begin a block; sampled only in IDLE
- `hash_in`  in  256  chaining value H0..H7, with H0 in bits [255:224]; sampled with `start`
- `w_valid`  in  1  `w_word` holds W[`w_index`] this cycle
- `w_word`  in  32  schedule word from the schedule stage (its `cur_w`)
- `w_index`  out  6  index of the word requested next; drives the schedule stage's index input
- `busy`  out  1  high in ROUND and FINAL
- `digest`  out  256  H0'..H7', with H0' in bits [255:224]; holds until the next completion
- `digest_valid`  out  1  one-cycle pulse when `digest` updates

## Operation
- States: IDLE, ROUND, FINAL.
- **IDLE**
  - `start`=1: latch `hash_in` into H[0..7] and into working registers a..h.
  - Clear the round counter and go to ROUND.
- **ROUND**
  - On a cycle with `w_valid`=1, apply one round using K[round] and `w_word`:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K + W
    - T2 = Σ0(a) + Maj(a,b,c)
    - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2
    - Increment the round counter.
  - On a cycle with `w_valid`=0, working registers and counter hold (stall).
  - After round 63 is applied, go to FINAL.
- **FINAL**
  - `digest` ← {H0+a, …, H7+h}; `digest_valid` ← 1.
  - Go to IDLE.
- Functions:
  - Σ0 = ROTR2^ROTR13^ROTR22
  - Σ1 = ROTR6^ROTR11^ROTR25
  - Ch = (e&f)^(~e&g)
  - Maj = (a&b)^(a&c)^(b&c)
- All additions are modulo 2^32; carries are discarded.
- `w_index` equals the round counter in ROUND and is 0 in IDLE and FINAL.
- `start` while `busy` is ignored. It is not queued.
- `w_valid` outside ROUND is ignored.

## Timing
- Reset values:
  - state IDLE, counter 0
  - `busy` 0, `w_index` 0
  - `digest` 0, `digest_valid` 0
  - a..h and H[0..7] all 0
- Reset mid-operation aborts the block. The next cycle is IDLE with no `digest_valid` pulse.
- Reset has priority over every other input.
- Edge sequence for a block with no stalls:
  - `start` sampled at edge 0
  - rounds 0..63 applied at edges 1..64
  - FINAL evaluated at edge 65
  - `digest_valid` high for the cycle after edge 65
- Latency:
  - no stalls: start to `digest_valid` is 65 cycles
  - each `w_valid`=0 cycle in ROUND adds exactly one cycle
- `start` may be asserted in the same cycle `digest_valid` is high, since the state is IDLE then. The new block begins and `digest` keeps its value.
- `w_index` is registered. The schedule stage has that cycle to present W[`w_index`] combinationally or registered; `w_valid` qualifies it.

## Structure
- Shared package `sha256_pkg` holds:
  - the K[0..63] round-constant array
  - the IV constant H0..H7 (6a09e667 … 5be0cd19)
  - the state enum {IDLE, ROUND, FINAL}
  - Σ0/Σ1/Ch/Maj functions, for reuse by the schedule stage's σ0/σ1 neighbours
- One sub-module, `sha256_round`:
  - purely combinational
  - inputs: a..h, K, W
  - outputs: next a..h
- `sha256_compress` holds the FSM, counter, registers and feed-forward adders.

## Test plan
- Reset sanity: assert `reset` 2 cycles → all outputs 0, `busy`=0, `w_index`=0.
- Single block "abc":
  - stimulus: `hash_in`=IV, W from padded "abc" (W0=61626380, W15=00000018), `w_valid` held high
  - response: `digest`=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad
  - `digest_valid` exactly one cycle, 65 cycles after start
- Empty message, IV:
  - `w_valid` deasserted on rounds 0, 17 and 63 for 3 cycles each
  - response: digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855
  - latency 74 cycles
- Abort:
  - stimulus: `reset` pulsed at round 30, then "abc" restarted
  - response: no pulse from the aborted block; correct "abc" digest at 65 cycles
- Spurious start:
  - stimulus: `start` with `hash_in`=0 pulsed at round 10 of the "abc" block
  - response: ignored; "abc" digest unchanged
- Two-block chaining:
  - stimulus: 448-bit test message "abcdbcdecdef…nopq"; block 1 digest fed back as `hash_in` with `start` in the `digest_valid` cycle
  - response: final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM encodings and round functions.
// Latency: none (package only).
// Backpressure: n/a.
package sha256_pkg;

  localparam int ROUNDS = 64;

  // Compression FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;

  // Eight 32-bit words a..h (or H0..H7); a / H0 sits in the top bits
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  // Initial hash value H0..H7
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Round constants K[0..63]
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotate right by a constant amount (1..31)
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round: a..h, K, W -> next a..h.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] h,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output logic [31:0] next_a,
  output logic [31:0] next_b,
  output logic [31:0] next_c,
  output logic [31:0] next_d,
  output logic [31:0] next_e,
  output logic [31:0] next_f,
  output logic [31:0] next_g,
  output logic [31:0] next_h
);

  logic [31:0] t1;
  logic [31:0] t2;

  // Round temporaries and the a..h shift; all sums wrap modulo 2^32
  always_comb begin
    t1     = h + big_sigma1(e) + ch(e, f, g) + k + w;
    t2     = big_sigma0(a) + maj(a, b, c);
    next_a = t1 + t2;
    next_b = a;
    next_c = b;
    next_d = c;
    next_e = d + t1;
    next_f = e;
    next_g = f;
    next_h = g;
  end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression: 64 rounds (one per accepted schedule word) plus feed-forward.
// Latency: start to digest_valid is 65 cycles, plus one per w_valid=0 cycle in ROUND.
// Backpressure: w_valid=0 stalls the round in place; start is ignored while busy.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] hash_in,
  input  logic         w_valid,
  input  logic [31:0]  w_word,
  output logic [5:0]   w_index,
  output logic         busy,
  output logic [255:0] digest,
  output logic         digest_valid
);

  logic [1:0] state;
  logic [5:0] round_cnt;
  work_t      work;
  work_t      chain;
  work_t      next_work;
  work_t      feed_fwd;

  sha256_round u_round (
    .a      (work.a),
    .b      (work.b),
    .c      (work.c),
    .d      (work.d),
    .e      (work.e),
    .f      (work.f),
    .g      (work.g),
    .h      (work.h),
    .k      (K[round_cnt]),
    .w      (w_word),
    .next_a (next_work.a),
    .next_b (next_work.b),
    .next_c (next_work.c),
    .next_d (next_work.d),
    .next_e (next_work.e),
    .next_f (next_work.f),
    .next_g (next_work.g),
    .next_h (next_work.h)
  );

  // Feed-forward: add the block's working state onto its chaining value
  always_comb begin
    feed_fwd.a = chain.a + work.a;
    feed_fwd.b = chain.b + work.b;
    feed_fwd.c = chain.c + work.c;
    feed_fwd.d = chain.d + work.d;
    feed_fwd.e = chain.e + work.e;
    feed_fwd.f = chain.f + work.f;
    feed_fwd.g = chain.g + work.g;
    feed_fwd.h = chain.h + work.h;
  end

  // The counter wraps 63 -> 0 on the last round, so it is already 0 in FINAL
  // and IDLE and can drive the schedule stage's index directly.
  assign w_index = round_cnt;
  assign busy    = (state != ST_IDLE);

  // FSM, round counter and the working / chaining registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      round_cnt    <= 6'd0;
      work         <= '0;
      chain        <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      digest_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            chain     <= work_t'(hash_in);
            work      <= work_t'(hash_in);
            round_cnt <= 6'd0;
            state     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (w_valid) begin
            work      <= next_work;
            round_cnt <= round_cnt + 6'd1;
            if (round_cnt == 6'(ROUNDS - 1)) begin
              state <= ST_FINAL;
            end
          end
        end
        ST_FINAL: begin
          digest       <= feed_fwd;
          digest_valid <= 1'b1;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress; the message schedule is expanded here.
// Latency: n/a.
// Backpressure: w_valid stall patterns are driven per test.
module tb_sha256_compress;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] hash_in;
  logic         w_valid;
  logic [31:0]  w_word;
  logic [5:0]   w_index;
  logic         busy;
  logic [255:0] digest;
  logic         digest_valid;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] sched [0:63];

  localparam logic [255:0] IV_VAL = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  always #5 clock = ~clock;

  // Combinational schedule stage: present W[w_index] every cycle
  assign w_word = sched[w_index];

  sha256_compress dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .hash_in      (hash_in),
    .w_valid      (w_valid),
    .w_word       (w_word),
    .w_index      (w_index),
    .busy         (busy),
    .digest       (digest),
    .digest_valid (digest_valid)
  );

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  // Expand a 512-bit block into W[0..63]
  task automatic load_sched(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) sched[i] = blk[511 - 32*i -: 32];
    for (int t = 16; t < 64; t++)
      sched[t] = ssig1(sched[t-2]) + sched[t-7] + ssig0(sched[t-15]) + sched[t-16];
  endtask

  // Entered and left at a negedge. Starts a block, feeds words with optional
  // 3-way stall plan and an optional spurious start, returns at the negedge
  // where digest_valid is seen (lat = edges after the start edge, -1 on timeout).
  task automatic run_block(input logic [255:0] hin, input int s0, input int s1,
                           input int s2, input int slen, input int spur,
                           output logic [255:0] dig, output int lat);
    int  stall_cnt [0:63];
    int  expect_idx;
    int  cycles;
    bit  spur_done;
    bit  final_checked;
    bit  seen;
    for (int i = 0; i < 64; i++) stall_cnt[i] = 0;
    expect_idx = 0; cycles = 0; spur_done = 0; final_checked = 0; seen = 0;
    lat = -1; dig = '0;
    start = 1'b1; hash_in = hin; w_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    while (cycles < 200 && !seen) begin
      if (expect_idx < 64) begin
        vectors++;
        if (w_index !== 6'(expect_idx) || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL round_index: w_index=%0d busy=%b, expected w_index=%0d busy=1",
                   w_index, busy, expect_idx);
        end
      end else if (!final_checked) begin
        final_checked = 1;
        vectors++;
        if (w_index !== 6'd0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL final_state: w_index=%0d busy=%b, expected 0 and 1", w_index, busy);
        end
      end
      start = 1'b0;
      if (expect_idx < 64 && expect_idx == spur && !spur_done) begin
        start = 1'b1; hash_in = '0; spur_done = 1;
      end
      if (expect_idx < 64 && (expect_idx == s0 || expect_idx == s1 || expect_idx == s2)
          && stall_cnt[expect_idx] < slen) begin
        w_valid = 1'b0;
        stall_cnt[expect_idx]++;
      end else if (expect_idx < 64) begin
        w_valid = 1'b1;
        expect_idx++;
      end else begin
        w_valid = 1'b0;
      end
      @(posedge clock);
      cycles++;
      @(negedge clock);
      if (digest_valid === 1'b1) begin
        seen = 1; lat = cycles; dig = digest;
      end
    end
    start = 1'b0; w_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; hash_in = '0; w_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++;
    if (w_index !== 6'd0) begin miscompares++; $display("FAIL reset_w_index: got %0d want 0", w_index); end
    vectors++;
    if (digest !== 256'd0) begin miscompares++; $display("FAIL reset_digest: got %h want 0", digest); end
    vectors++;
    if (digest_valid !== 1'b0) begin miscompares++; $display("FAIL reset_digest_valid: got %b want 0", digest_valid); end
    reset = 1'b0;
  endtask

  task automatic test_abc;
    logic [255:0] dig;
    int           lat;
    load_sched(ABC_BLK);
    run_block(IV_VAL, -1, -1, -1, 0, -1, dig, lat);
    vectors++;
    if (dig !== ABC_DIG) begin miscompares++; $display("FAIL abc_digest: got %h want %h", dig, ABC_DIG); end
    vectors++;
    if (lat !== 65) begin miscompares++; $display("FAIL abc_latency: got %0d want 65", lat); end
    @(negedge clock);
    vectors++;
    if (digest_valid !== 1'b0) begin miscompares++; $display("FAIL abc_pulse_width: digest_valid=%b want 0", digest_valid); end
    vectors++;
    if (digest !== ABC_DIG) begin miscompares++; $display("FAIL abc_digest_hold: got %h want %h", digest, ABC_DIG); end
  endtask

  task automatic test_empty_stalls;
    logic [255:0] dig;
    int           lat;
    load_sched(EMPTY_BLK);
    run_block(IV_VAL, 0, 17, 63, 3, -1, dig, lat);
    vectors++;
    if (dig !== EMPTY_DIG) begin miscompares++; $display("FAIL empty_digest: got %h want %h", dig, EMPTY_DIG); end
    vectors++;
    if (lat !== 74) begin miscompares++; $display("FAIL empty_latency: got %0d want 74", lat); end
  endtask

  task automatic test_abort;
    logic [255:0] dig;
    int           lat;
    int           pulses;
    int           guard;
    load_sched(ABC_BLK);
    start = 1'b1; hash_in = IV_VAL; w_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    guard = 0;
    while (w_index !== 6'd30 && guard < 100) begin
      @(posedge clock);
      @(negedge clock);
      guard++;
    end
    vectors++;
    if (w_index !== 6'd30) begin miscompares++; $display("FAIL abort_reach_round30: w_index=%0d want 30", w_index); end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0; w_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0 || w_index !== 6'd0) begin
      miscompares++; $display("FAIL abort_idle: busy=%b w_index=%0d want 0 and 0", busy, w_index);
    end
    vectors++;
    if (digest !== 256'd0 || digest_valid !== 1'b0) begin
      miscompares++; $display("FAIL abort_outputs: digest=%h valid=%b want 0 and 0", digest, digest_valid);
    end
    pulses = 0;
    repeat (80) begin
      @(posedge clock);
      @(negedge clock);
      if (digest_valid === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL abort_no_pulse: got %0d pulses want 0", pulses); end
    run_block(IV_VAL, -1, -1, -1, 0, -1, dig, lat);
    vectors++;
    if (dig !== ABC_DIG) begin miscompares++; $display("FAIL abort_restart_digest: got %h want %h", dig, ABC_DIG); end
    vectors++;
    if (lat !== 65) begin miscompares++; $display("FAIL abort_restart_latency: got %0d want 65", lat); end
  endtask

  task automatic test_spurious_start;
    logic [255:0] dig;
    int           lat;
    load_sched(ABC_BLK);
    run_block(IV_VAL, -1, -1, -1, 0, 10, dig, lat);
    vectors++;
    if (dig !== ABC_DIG) begin miscompares++; $display("FAIL spurious_digest: got %h want %h", dig, ABC_DIG); end
    vectors++;
    if (lat !== 65) begin miscompares++; $display("FAIL spurious_latency: got %0d want 65", lat); end
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL spurious_not_queued: busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [255:0] dig1;
    logic [255:0] dig2;
    int           lat1;
    int           lat2;
    load_sched(TWO_BLK1);
    run_block(IV_VAL, -1, -1, -1, 0, -1, dig1, lat1);
    vectors++;
    if (lat1 !== 65) begin miscompares++; $display("FAIL chain_blk1_latency: got %0d want 65", lat1); end
    // Still in the digest_valid cycle: start block 2 right away
    load_sched(TWO_BLK2);
    run_block(dig1, -1, -1, -1, 0, -1, dig2, lat2);
    vectors++;
    if (dig2 !== TWO_DIG) begin miscompares++; $display("FAIL chain_digest: got %h want %h", dig2, TWO_DIG); end
    vectors++;
    if (lat2 !== 65) begin miscompares++; $display("FAIL chain_blk2_latency: got %0d want 65", lat2); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hash_in = '0; w_valid = 1'b0;
    for (int i = 0; i < 64; i++) sched[i] = '0;
    @(negedge clock);
    test_reset();
    test_abc();
    test_empty_stalls();
    test_abort();
    test_spurious_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
